// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package uart_arb_pkg;

    localparam int ByteW = 8;

    typedef enum logic {
        ArbIdle   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

    // Scan valid from ptr upward, wrapping at n with an explicit compare.
    // Returns the first valid index; when nothing is valid, returns ptr.
    function automatic int rr_next(input int ptr, input logic [7:0] valid, input int n);
        int   idx;
        logic found;
        rr_next = ptr;
        idx     = ptr;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                if (!found && valid[idx[2:0]]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
                idx = (idx == n - 1) ? 0 : idx + 1;
            end
        end
    endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Round-robin pick: first valid requester at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NumReq = 4,
    localparam int IdxW = $clog2(NumReq)
) (
    input  logic [IdxW-1:0]   ptr_i,
    input  logic [NumReq-1:0] valid_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    // Rotate-and-encode expressed as a bounded wrap-around scan.
    always_comb begin
        any_o = |valid_i;
        idx_o = IdxW'(rr_next(32'(ptr_i), 8'(valid_i), NumReq));
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locking round-robin arbiter feeding one UART TX byte stream.
// Latency: grant one cycle after request; byte appears one cycle after transfer.
// Backpressure: owner ready = stage empty or downstream ready; stage reloads with no bubble.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NumReq   = 4,
    parameter int MaxBurst = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq*ByteW-1:0] req_data_i,
    input  logic [NumReq-1:0]       req_last_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic                    tx_valid_o,
    output logic [ByteW-1:0]        tx_data_o,
    input  logic                    tx_ready_i,
    output logic [NumReq-1:0]       grant_o,
    output logic                    busy_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(MaxBurst + 1);

    arb_state_e       state_q, state_d;
    logic [IdxW-1:0]  owner_q, owner_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             tx_valid_q, tx_valid_d;
    logic [ByteW-1:0] tx_data_q, tx_data_d;

    logic [IdxW-1:0]  pick_idx;
    logic             pick_any;
    logic             own_valid;
    logic             own_last;
    logic [ByteW-1:0] own_data;
    logic             stage_free;
    logic             xfer;
    logic [CntW-1:0]  cnt_inc;

    uart_arb_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .ptr_i   (ptr_q),
        .valid_i (req_valid_i),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Select the current owner's byte, valid and last flag.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (owner_q == IdxW'(k)) begin
                own_valid = req_valid_i[k];
                own_last  = req_last_i[k];
                own_data  = req_data_i[k*ByteW +: ByteW];
            end
        end
    end

    // Owner-only ready and one-hot grant; both are zero while idle.
    always_comb begin
        stage_free  = !tx_valid_q || tx_ready_i;
        req_ready_o = '0;
        grant_o     = '0;
        if (state_q == ArbLocked) begin
            for (int k = 0; k < NumReq; k++) begin
                if (owner_q == IdxW'(k)) begin
                    grant_o[k]     = 1'b1;
                    req_ready_o[k] = stage_free;
                end
            end
        end
        xfer       = (state_q == ArbLocked) && own_valid && stage_free;
        busy_o     = (state_q == ArbLocked);
        tx_valid_o = tx_valid_q;
        tx_data_o  = tx_data_q;
    end

    // Next-state: arbitration, burst counting, release, and the output stage.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        cnt_inc    = cnt_q + CntW'(1);

        case (state_q)
            ArbIdle: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ArbLocked;
                end
            end
            ArbLocked: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    // Last byte and burst cap in the same transfer are one release.
                    if (own_last || (cnt_inc == CntW'(MaxBurst))) begin
                        state_d = ArbIdle;
                        ptr_d   = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);
                    end
                end
            end
            default: state_d = ArbIdle;
        endcase

        if (xfer) begin
            tx_valid_d = 1'b1;
            tx_data_d  = own_data;
        end else if (tx_ready_i) begin
            tx_valid_d = 1'b0;
        end
    end

    // All state registers; reset discards any byte held in the stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ArbIdle;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: cycle reference model plus directed byte/grant checks.
// Latency: n/a.
// Backpressure: drives random downstream ready and random requester gaps.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int MB = 16;
    localparam int LOGN = 16384;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   req_valid_i;
    logic [N*8-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic           tx_valid_o;
    logic [7:0]     tx_data_o;
    logic           tx_ready_i;
    logic [N-1:0]   grant_o;
    logic           busy_o;

    always #5 clk_i = ~clk_i;

    uart_tx_arb #(.NumReq(N), .MaxBurst(MB)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ent_t;

    // Per-requester packet byte queues (circular, 256 deep).
    ent_t qbuf [N][256];
    int   head [N];
    int   tail [N];
    logic [N-1:0] en;
    logic trdy;

    // Reference model: owner (-1 = idle), rotation pointer, burst count, output stage.
    int         m_own, m_ptr, m_cnt;
    logic       m_tv;
    logic [7:0] m_td;

    int         cyc;
    logic [N-1:0] gnt_log [LOGN];
    logic [N-1:0] rdy_log [LOGN];
    logic         tv_log  [LOGN];
    logic [7:0]   td_log  [LOGN];
    logic [7:0]   out_b   [LOGN];
    int           out_c   [LOGN];
    int           n_out;

    int   checks, errors;
    bit   ord_chk;
    logic [5:0] exp_seq [N];
    logic [5:0] gen_seq [N];
    int   gen_cnt, del_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        qbuf[k][8'(tail[k])] = '{d: d, l: l};
        tail[k]++;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int k = 0; k < N; k++) if (head[k] != tail[k]) p = 1'b1;
        return p;
    endfunction

    // One clock: drive, compare against model, log, advance model and queues.
    task automatic step();
        logic [N-1:0]   v, l;
        logic [N*8-1:0] d;
        logic [N-1:0]   eg, er;
        int n_own, n_ptr, n_cnt;
        logic n_tv;
        logic [7:0] n_td;
        bit found;
        v = '0; l = '0; d = '0;
        for (int k = 0; k < N; k++) begin
            if (en[k] && head[k] != tail[k]) begin
                v[k]         = 1'b1;
                l[k]         = qbuf[k][8'(head[k])].l;
                d[k*8 +: 8]  = qbuf[k][8'(head[k])].d;
            end
        end
        req_valid_i = v;
        req_last_i  = l;
        req_data_i  = d;
        tx_ready_i  = trdy;
        #1;
        eg = (m_own >= 0) ? N'(1 << m_own) : '0;
        er = ((m_own >= 0) && (!m_tv || trdy)) ? eg : '0;
        chk("grant",    32'(grant_o),     32'(eg));
        chk("busy",     32'(busy_o),      32'(m_own >= 0));
        chk("ready",    32'(req_ready_o), 32'(er));
        chk("tx_valid", 32'(tx_valid_o),  32'(m_tv));
        chk("tx_data",  32'(tx_data_o),   32'(m_td));
        if (cyc < LOGN) begin
            gnt_log[cyc] = grant_o;
            rdy_log[cyc] = req_ready_o;
            tv_log[cyc]  = tx_valid_o;
            td_log[cyc]  = tx_data_o;
        end
        if (tx_valid_o && tx_ready_i) begin
            if (n_out < LOGN) begin
                out_b[n_out] = tx_data_o;
                out_c[n_out] = cyc;
                n_out++;
            end
            del_cnt++;
            if (ord_chk) begin
                chk("byte_order", 32'(tx_data_o[5:0]), 32'(exp_seq[int'(tx_data_o[7:6])]));
                exp_seq[int'(tx_data_o[7:6])]++;
            end
        end
        for (int k = 0; k < N; k++) if (v[k] && req_ready_o[k]) head[k]++;

        n_own = m_own; n_ptr = m_ptr; n_cnt = m_cnt; n_tv = m_tv; n_td = m_td;
        if (m_own < 0) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!found && v[(m_ptr + i) % N]) begin
                    n_own = (m_ptr + i) % N;
                    n_cnt = 0;
                    found = 1'b1;
                end
            end
            if (trdy) n_tv = 1'b0;
        end else if (v[m_own] && er[m_own]) begin
            n_tv  = 1'b1;
            n_td  = d[m_own*8 +: 8];
            n_cnt = m_cnt + 1;
            if (l[m_own] || n_cnt == MB) begin
                n_own = -1;
                n_ptr = (m_own + 1) % N;
            end
        end else if (trdy) begin
            n_tv = 1'b0;
        end
        @(posedge clk_i);
        #1;
        m_own = n_own; m_ptr = n_ptr; m_cnt = n_cnt; m_tv = n_tv; m_td = n_td;
        cyc++;
    endtask

    task automatic run_until_idle(input int cap);
        int n = 0;
        while ((pending() || m_own >= 0 || m_tv) && n < cap) begin
            step();
            n++;
        end
        chk("drain_done", 32'(n < cap), 32'd1);
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        tx_ready_i  = 1'b1;
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        m_own = -1; m_ptr = 0; m_cnt = 0; m_tv = 1'b0; m_td = 8'h00;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int cs, n0, cnt1;
        logic [7:0] exp_b [22];
        checks = 0; errors = 0; cyc = 0; n_out = 0;
        ord_chk = 1'b0; gen_cnt = 0; del_cnt = 0;
        en = '1; trdy = 1'b1;
        rst_ni = 1'b0;
        req_valid_i = '0; req_last_i = '0; req_data_i = '0; tx_ready_i = 1'b1;
        #3;
        chk("rst_tx_valid", 32'(tx_valid_o),  32'd0);
        chk("rst_tx_data",  32'(tx_data_o),   32'h00);
        chk("rst_grant",    32'(grant_o),     32'd0);
        chk("rst_busy",     32'(busy_o),      32'd0);
        chk("rst_ready",    32'(req_ready_o), 32'd0);
        do_reset();

        // Single requester, 3-byte packet.
        cs = cyc; n0 = n_out;
        push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
        run_until_idle(50);
        chk("single_grant", 32'(gnt_log[cs+1]), 32'b0100);
        chk("single_b0", 32'(out_b[n0]),   32'h41);
        chk("single_b1", 32'(out_b[n0+1]), 32'h42);
        chk("single_b2", 32'(out_b[n0+2]), 32'h43);
        chk("single_lat",  out_c[n0],   cs + 2);
        chk("single_c1",   out_c[n0+1], cs + 3);
        chk("single_c2",   out_c[n0+2], cs + 4);
        cs = cyc;
        push(0, 8'h11, 1'b1); push(3, 8'h33, 1'b1);
        run_until_idle(50);
        chk("ptr_after_single", 32'(gnt_log[cs+1]), 32'b1000);

        // Round-robin with continuous 1-byte packets.
        do_reset();
        cs = cyc;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push(k, 8'(k), 1'b1);
        run_until_idle(100);
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant", 32'(gnt_log[cs+1+2*i]), 32'(1 << (i % 4)));
            chk("rr_gap",   32'(gnt_log[cs+2+2*i]), 32'd0);
        end

        // Burst cap with a competing requester.
        do_reset();
        n0 = n_out;
        for (int i = 0; i < 20; i++) push(0, 8'(i), i == 19);
        push(1, 8'hA0, 1'b0); push(1, 8'hA1, 1'b1);
        for (int i = 0; i < 16; i++) exp_b[i] = 8'(i);
        exp_b[16] = 8'hA0; exp_b[17] = 8'hA1;
        for (int i = 0; i < 4; i++) exp_b[18+i] = 8'(16 + i);
        run_until_idle(200);
        chk("cap_count", n_out - n0, 22);
        for (int i = 0; i < 22; i++) chk("cap_byte", 32'(out_b[n0+i]), 32'(exp_b[i]));

        // Backpressure: 5 stalled cycles mid-packet.
        do_reset();
        n0 = n_out; cs = cyc;
        for (int i = 0; i < 8; i++) push(1, 8'(8'h50 + i), i == 7);
        trdy = 1'b1;
        repeat (4) step();
        trdy = 1'b0;
        repeat (5) step();
        trdy = 1'b1;
        run_until_idle(100);
        for (int c = cs + 4; c < cs + 9; c++) begin
            chk("bp_ready", 32'(rdy_log[c]), 32'd0);
            chk("bp_valid", 32'(tv_log[c]),  32'd1);
            chk("bp_hold",  32'(td_log[c]),  32'h52);
        end
        chk("bp_count", n_out - n0, 8);
        for (int i = 0; i < 8; i++) chk("bp_byte", 32'(out_b[n0+i]), 32'h50 + i);

        // Last byte coincides with the burst cap.
        do_reset();
        cs = cyc;
        for (int i = 0; i < 16; i++) push(0, 8'(8'h60 + i), i == 15);
        push(0, 8'h70, 1'b1);
        push(1, 8'h80, 1'b1);
        run_until_idle(100);
        cnt1 = 0;
        for (int i = 1; i <= 16; i++) if (gnt_log[cs+i] == 4'b0001) cnt1++;
        chk("coinc_len",  cnt1, 16);
        chk("coinc_gap",  32'(gnt_log[cs+17]), 32'd0);
        chk("coinc_next", 32'(gnt_log[cs+18]), 32'b0010);

        // Reset mid-burst.
        do_reset();
        push(2, 8'h22, 1'b1);
        run_until_idle(50);
        for (int i = 0; i < 10; i++) push(1, 8'(8'h30 + i), i == 9);
        repeat (4) step();
        chk("pre_rst_valid", 32'(tx_valid_o), 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(tx_valid_o),  32'd0);
        chk("arst_tx_data",  32'(tx_data_o),   32'h00);
        chk("arst_grant",    32'(grant_o),     32'd0);
        chk("arst_busy",     32'(busy_o),      32'd0);
        chk("arst_ready",    32'(req_ready_o), 32'd0);
        do_reset();
        cs = cyc;
        push(3, 8'h33, 1'b1); push(0, 8'h00, 1'b1);
        run_until_idle(50);
        chk("post_rst_grant", 32'(gnt_log[cs+1]), 32'b0001);

        // Randomized traffic with gaps and downstream stalls.
        do_reset();
        ord_chk = 1'b1; gen_cnt = 0; del_cnt = 0;
        for (int k = 0; k < N; k++) begin
            exp_seq[k] = '0;
            gen_seq[k] = '0;
        end
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                int k, len;
                k   = int'($urandom_range(0, N - 1));
                len = int'($urandom_range(1, 20));
                if (tail[k] - head[k] + len < 200) begin
                    for (int i = 0; i < len; i++) begin
                        push(k, {2'(k), gen_seq[k]}, i == len - 1);
                        gen_seq[k]++;
                        gen_cnt++;
                    end
                end
            end
            for (int k = 0; k < N; k++) en[k] = ($urandom_range(0, 9) < 8);
            trdy = ($urandom_range(0, 9) < 7);
            step();
        end
        en = '1; trdy = 1'b1;
        run_until_idle(3000);
        chk("rand_delivered", del_cnt, gen_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
